mul_result_collector: RTL and testbench

Downstream stage of the bf16 multiplier tree. Each cycle it accepts the tree's packed 4-lane result bus and per-lane strobes, compacts the valid lanes in ascending lane order, and buffers them in a circular FIFO. It drains the FIFO one bf16 word per cycle over a valid/ack handshake. The tree has no backpressure, so the block raises `almost_full` for the operand feeder to stall on, and it counts and flags any result group it has to drop.

---
 rtl/mul_result_collector.sv | 159 +++++++++++++++
 tb/tb_mul_result_collector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_result_collector.sv
// mul_result_collector
// Collects the 4-lane bf16 result bus of the multiplier tree, compacts the
// strobed lanes in ascending lane order and queues them in a circular FIFO
// that drains one word per cycle over an out_stb/out_ack handshake.
// Groups that do not fit are dropped whole and accounted in overflow/drop_cnt.
module mul_result_collector #(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              in_data,
    input  logic [3:0]               in_stbs,
    output logic [15:0]              out_data,
    output logic [1:0]               out_lane,
    output logic                     out_stb,
    input  logic                     out_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_overflow
);

    localparam int LANES = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // One extra bit so free-slot arithmetic can never wrap.
    localparam int ARITH_W = CNT_W + 1;
    localparam logic [ARITH_W-1:0] DEPTH_EXT   = ARITH_W'(DEPTH);
    localparam logic [ARITH_W-1:0] AFULL_LEVEL = ARITH_W'(DEPTH - AFULL_MARGIN);

    // Each entry holds {source lane, bf16 word}.
    logic [17:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             almost_full_reg, almost_full_next;
    logic             overflow_reg, overflow_next;
    logic [7:0]       drop_cnt_reg, drop_cnt_next;

    // prefix[k] = number of strobed lanes below lane k, i.e. the write offset
    // of lane k within the compacted group; prefix[LANES] is the group size.
    logic [2:0]       prefix [LANES+1];
    logic [PTR_W-1:0] wr_slot [LANES];
    logic [2:0]       grp_n;

    logic               pop;
    logic [ARITH_W-1:0] free_slots;
    logic [ARITH_W-1:0] grp_n_ext;
    logic               accept;
    logic               drop;
    logic [2:0]         push_n;
    logic [17:0]        head_entry;

    assign prefix[0] = 3'd0;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign prefix[gi+1] = prefix[gi] + {2'b00, in_stbs[gi]};
            // Offsets never exceed 3, so truncation to PTR_W bits is a clean
            // modulo-DEPTH wrap even at the minimum depth of 4.
            assign wr_slot[gi]  = wr_ptr_reg + PTR_W'(prefix[gi]);
        end
    endgenerate

    assign grp_n = prefix[LANES];

    // Handshake: acks while empty are ignored because out_stb is low.
    assign pop = out_stb & out_ack;

    // A same-cycle pop frees a slot for the group arriving this cycle.
    assign free_slots = DEPTH_EXT - {1'b0, count_reg} + {{(ARITH_W-1){1'b0}}, pop};
    assign grp_n_ext  = ARITH_W'(grp_n);
    assign accept     = (grp_n_ext <= free_slots);
    // An empty group always fits, so a drop implies at least one strobe.
    assign drop       = ~accept;
    assign push_n     = accept ? grp_n : 3'd0;

    // Next-state arithmetic for pointers, occupancy and drop accounting.
    always_comb begin
        logic [7:0] drop_base;
        logic [8:0] drop_sum;
        logic [ARITH_W-1:0] count_next_ext;

        wr_ptr_next      = wr_ptr_reg + PTR_W'(push_n);
        rd_ptr_next      = rd_ptr_reg + {{(PTR_W-1){1'b0}}, pop};
        count_next       = count_reg + CNT_W'(push_n) - {{(CNT_W-1){1'b0}}, pop};
        count_next_ext   = {1'b0, count_next};
        almost_full_next = (count_next_ext > AFULL_LEVEL);

        // A clear in the same cycle as a drop restarts the tally from this
        // group instead of adding to the old sum.
        drop_base = clr_overflow ? 8'd0 : drop_cnt_reg;
        drop_sum  = {1'b0, drop_base} + {6'd0, grp_n};

        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        if (drop) begin
            overflow_next = 1'b1;
            drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end else if (clr_overflow) begin
            overflow_next = 1'b0;
            drop_cnt_next = 8'd0;
        end
    end

    // Control registers; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            almost_full_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            drop_cnt_reg    <= 8'd0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            almost_full_reg <= almost_full_next;
            overflow_reg    <= overflow_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    // Storage writes: every strobed lane of an accepted group lands in its
    // compacted slot; lanes of a dropped group and writes in reset are ignored.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (rst && accept && in_stbs[i]) begin
                mem[wr_slot[i]] <= {2'(i), in_data[16*i +: 16]};
            end
        end
    end

    // Head of queue is read combinationally so a word pushed at one edge is
    // presented in the very next cycle.
    assign head_entry = mem[rd_ptr_reg];

    // Output gating: present zeros whenever the FIFO is empty.
    always_comb begin
        out_stb  = (count_reg != '0);
        out_data = 16'h0000;
        out_lane = 2'b00;
        if (out_stb) begin
            out_data = head_entry[15:0];
            out_lane = head_entry[17:16];
        end
    end

    assign count       = count_reg;
    assign almost_full = almost_full_reg;
    assign overflow    = overflow_reg;
    assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_mul_result_collector.sv
// Testbench for mul_result_collector: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_mul_result_collector;

    localparam int DEPTH = 16;
    localparam int AFULL_MARGIN = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [3:0]  in_stbs;
    logic [15:0] out_data;
    logic [1:0]  out_lane;
    logic        out_stb;
    logic        out_ack;
    logic [4:0]  count;
    logic        almost_full;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state.
    logic [17:0] mq[$];
    int          m_dc  = 0;
    bit          m_ovf = 1'b0;
    bit          m_af  = 1'b0;

    mul_result_collector #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_stbs     (in_stbs),
        .out_data    (out_data),
        .out_lane    (out_lane),
        .out_stb     (out_stb),
        .out_ack     (out_ack),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive, advance the model, clock, then compare.
    task automatic step(input logic [3:0] s, input logic [63:0] d,
                        input logic a, input logic c, input logic r);
        int n;
        int free;
        bit pop;
        logic [17:0] head;
        rst = r; in_stbs = s; in_data = d; out_ack = a; clr_overflow = c;

        if (!r) begin
            mq.delete();
            m_dc = 0; m_ovf = 1'b0; m_af = 1'b0;
        end else begin
            n    = $countones(s);
            pop  = (mq.size() != 0) && a;
            free = DEPTH - mq.size() + int'(pop);
            if (pop) void'(mq.pop_front());
            if (n <= free) begin
                for (int k = 0; k < 4; k++)
                    if (s[k]) mq.push_back({2'(k), d[16*k +: 16]});
                if (c) begin m_ovf = 1'b0; m_dc = 0; end
            end else begin
                m_ovf = 1'b1;
                m_dc  = (c ? 0 : m_dc) + n;
                if (m_dc > 255) m_dc = 255;
            end
            m_af = (mq.size() > DEPTH - AFULL_MARGIN);
        end

        @(posedge clk);
        #1;
        cyc++;
        head = (mq.size() != 0) ? mq[0] : 18'h0;
        check("count",       32'(count),       32'(mq.size()));
        check("out_stb",     32'(out_stb),     32'(mq.size() != 0));
        check("out_data",    32'(out_data),    32'(head[15:0]));
        check("out_lane",    32'(out_lane),    32'(head[17:16]));
        check("almost_full", 32'(almost_full), 32'(m_af));
        check("overflow",    32'(overflow),    32'(m_ovf));
        check("drop_cnt",    32'(drop_cnt),    32'(m_dc));
        $display("cyc %0d rst=%b stbs=%b ack=%b clr=%b -> count=%0d head=%h lane=%0d ovf=%b drops=%0d",
                 cyc, r, s, a, c, count, out_data, out_lane, overflow, drop_cnt);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic drain();
        for (int k = 0; k < 40 && mq.size() != 0; k++) step(4'b0000, 64'h0, 1'b1, 1'b0, 1'b1);
        check("drained_empty", 32'(out_stb), 32'(0));
    endtask

    initial begin
        rst = 1'b0; in_stbs = 4'h0; in_data = 64'h0; out_ack = 1'b0; clr_overflow = 1'b0;

        // Reset state.
        step(4'b0000, 64'h0, 1'b0, 1'b0, 1'b0);
        check("reset_count", 32'(count), 32'(0));
        check("reset_data",  32'(out_data), 32'(0));

        // Full 4-lane group, drained in lane order.
        step(4'b1111, 64'h4080_4040_4000_3F80, 1'b1, 1'b0, 1'b1);
        check("grp4_count", 32'(count), 32'(4));
        check("grp4_head",  32'(out_data), 32'h3F80);
        drain();
        check("grp4_empty_data", 32'(out_data), 32'(0));

        // Sparse strobe: only lanes 1 and 3 stored.
        step(4'b1010, 64'h4080_AAAA_4000_BBBB, 1'b0, 1'b0, 1'b1);
        check("sparse_count", 32'(count), 32'(2));
        check("sparse_head",  32'(out_data), 32'h4000);
        check("sparse_lane",  32'(out_lane), 32'(1));
        drain();

        // Fill to FULL without pops, then drop a fifth group.
        for (int g = 0; g < 4; g++) step(4'b1111, rnd64(), 1'b0, 1'b0, 1'b1);
        check("full_count", 32'(count), 32'(16));
        check("full_afull", 32'(almost_full), 32'(1));
        step(4'b1111, rnd64(), 1'b0, 1'b0, 1'b1);
        check("drop_count", 32'(count), 32'(16));
        check("drop_ovf",   32'(overflow), 32'(1));
        check("drop_cnt4",  32'(drop_cnt), 32'(4));

        // FULL with a pop accepts a single lane.
        step(4'b0001, 64'h0000_0000_0000_3F80, 1'b1, 1'b0, 1'b1);
        check("full_pop_count", 32'(count), 32'(16));
        check("full_pop_drops", 32'(drop_cnt), 32'(4));

        // Clear coinciding with a drop: the drop wins.
        step(4'b0111, rnd64(), 1'b0, 1'b1, 1'b1);
        check("clr_drop_ovf", 32'(overflow), 32'(1));
        check("clr_drop_cnt", 32'(drop_cnt), 32'(3));
        step(4'b0000, 64'h0, 1'b0, 1'b1, 1'b1);
        check("clr_ovf", 32'(overflow), 32'(0));
        check("clr_cnt", 32'(drop_cnt), 32'(0));
        drain();

        // 40 single words with random ack, across pointer wrap.
        for (int k = 0; k < 40; k++) begin
            logic [3:0] s;
            s = 4'b0001 << $urandom_range(0, 3);
            step(s, rnd64(), 1'($urandom_range(0, 3) != 0), 1'b0, 1'b1);
        end
        drain();

        // Random traffic including drops and clears.
        for (int k = 0; k < 200; k++) begin
            step(4'($urandom()), rnd64(), 1'($urandom()), 1'($urandom_range(0, 7) == 0), 1'b1);
        end
        drain();

        // Mid-stream reset at count 7.
        step(4'b1111, rnd64(), 1'b0, 1'b0, 1'b1);
        step(4'b0111, rnd64(), 1'b0, 1'b0, 1'b1);
        check("pre_rst_count", 32'(count), 32'(7));
        step(4'b1111, rnd64(), 1'b1, 1'b0, 1'b0);
        check("rst_count",   32'(count), 32'(0));
        check("rst_out_stb", 32'(out_stb), 32'(0));
        check("rst_drops",   32'(drop_cnt), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
